keypad_scan_debounce: RTL and testbench

Front-end stage of the keypad controller. It drives the columns of a 4x4 matrix keypad and samples the rows. It debounces whole scan frames and emits one single-cycle key event per clean press. The digit-entry logic downstream consumes `key_valid`/`key_code` directly.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_scan_debounce_if.sv | 12 +
 rtl/keypad_frame_encoder.sv | 22 ++
 rtl/keypad_scan_debounce.sv | 144 ++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM encoding and key map for the keypad scanner
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_MULTI   = 2'd2
   } kp_state_e;

   // Indexed by frame bit position col*4+row, so each group of four is one column.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h4, 4'h7, KEY_STAR,
      4'h2, 4'h5, 4'h8, 4'h0,
      4'h3, 4'h6, 4'h9, KEY_HASH,
      4'hA, 4'hB, 4'hC, 4'hD
   };

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// rtl/keypad_scan_debounce_if.sv - key event bundle from the scanner to the digit-entry logic
interface keypad_scan_debounce_if;

   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;
   logic       multi_key;

   modport master (output key_valid, key_code, key_held, multi_key);
   modport slave  (input  key_valid, key_code, key_held, multi_key);

endinterface

// File: rtl/keypad_frame_encoder.sv
// rtl/keypad_frame_encoder.sv - maps a 16-bit scan frame to a key code and a saturated key count
module keypad_frame_encoder
   import keypad_pkg::*;
(
   input  logic [15:0] frame_i,
   output logic [3:0]  code_o,
   output logic [1:0]  count_o
);

   // code_o is only meaningful when count_o == 1.
   always_comb begin
      code_o  = 4'h0;
      count_o = 2'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame_i[i]) begin
            code_o  = KEY_MAP[i];
            count_o = (count_o == 2'd0) ? 2'd1 : 2'd2;
         end
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad column scanner with whole-frame debounce and key events
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [3:0]                    row_in,
   output logic [3:0]                    col_out,
   keypad_scan_debounce_if.master        key_if
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

   logic [3:0]    row_s1_q, row_s2_q;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    col_out_q;
   logic [15:0]   frame_q, frame_d;
   logic [15:0]   prev_q;
   logic [15:0]   deb_q, deb_d;
   logic [CW-1:0] stable_q, stable_d;
   kp_state_e     state_q, state_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;

   logic          dwell_last, frame_end, deb_upd;
   logic [3:0]    enc_code;
   logic [1:0]    enc_count;

   assign dwell_last = (dwell_q == DWELL_LAST);
   assign frame_end  = dwell_last && (col_q == 2'd3);
   assign dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
   assign col_d      = dwell_last ? col_q + 2'd1 : col_q;

   always_comb begin
      frame_d = frame_q;
      if (dwell_last) begin
         frame_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
      end
   end

   always_comb begin
      if (frame_d == prev_q) begin
         stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
         stable_d = CW'(1);
      end
   end

   assign deb_upd = frame_end && (stable_d == CNT_MAX);
   assign deb_d   = deb_upd ? frame_d : deb_q;

   keypad_frame_encoder u_enc (
      .frame_i (deb_d),
      .code_o  (enc_code),
      .count_o (enc_count)
   );

   // The FSM only moves on a debounced-state update, so a held key re-evaluates once per frame.
   always_comb begin
      state_d     = state_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      if (deb_upd) begin
         case (state_q)
            ST_IDLE: begin
               if (enc_count == 2'd1) begin
                  state_d     = ST_PRESSED;
                  key_valid_d = 1'b1;
                  key_code_d  = enc_code;
               end else if (enc_count == 2'd2) begin
                  state_d = ST_MULTI;
               end
            end
            ST_PRESSED: begin
               if (enc_count == 2'd0)      state_d = ST_IDLE;
               else if (enc_count == 2'd2) state_d = ST_MULTI;
            end
            ST_MULTI: begin
               if (enc_count == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         dwell_q     <= '0;
         col_q       <= 2'd0;
         col_out_q   <= 4'b1110;
         frame_q     <= '0;
         prev_q      <= '0;
         deb_q       <= '0;
         stable_q    <= '0;
         state_q     <= ST_IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
      end else if (!ena) begin
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         dwell_q     <= '0;
         col_q       <= 2'd0;
         col_out_q   <= 4'hF;
         frame_q     <= '0;
         prev_q      <= '0;
         deb_q       <= '0;
         stable_q    <= '0;
         state_q     <= ST_IDLE;
         key_valid_q <= 1'b0;
      end else begin
         row_s1_q    <= row_in;
         row_s2_q    <= row_s1_q;
         dwell_q     <= dwell_d;
         col_q       <= col_d;
         col_out_q   <= ~(4'b0001 << col_d);
         frame_q     <= frame_d;
         if (frame_end) begin
            prev_q   <= frame_d;
            stable_q <= stable_d;
         end
         deb_q       <= deb_d;
         state_q     <= state_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   assign col_out          = col_out_q;
   assign key_if.key_valid = key_valid_q;
   assign key_if.key_code  = key_code_q;
   assign key_if.key_held  = (state_q == ST_PRESSED);
   assign key_if.multi_key = (state_q == ST_MULTI);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - keypad scanner bench with a frame-level reference model
module tb_keypad_scan_debounce;

   localparam int SD   = 4;
   localparam int DS   = 2;
   localparam int FR   = 4 * SD;
   localparam int MAXC = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] keys = '0;

   int checks = 0;
   int failures = 0;

   logic [15:0] sched [MAXC];
   logic [3:0]  e_col [MAXC];
   logic        e_valid [MAXC];
   logic [3:0]  e_code [MAXC];
   int          e_st [MAXC];
   logic [3:0]  model_code;

   keypad_scan_debounce_if kif ();

   keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .row_in  (row_in),
      .col_out (col_out),
      .key_if  (kif)
   );

   always #5 clk = ~clk;

   // Physical keypad: keys[row*4+col] shorts that row to the column when the column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] key_code_of(input logic [15:0] set);
      string km;
      byte   ch;
      km = "123A456B789C*0#D";
      ch = "0";
      for (int i = 0; i < 16; i++) if (set[i]) ch = km[i];
      if (ch >= "0" && ch <= "9") return 4'(ch - "0");
      if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 8'd10);
      if (ch == "*") return 4'hE;
      return 4'hF;
   endfunction

   // Frame f samples column c from the rows seen two cycles before its last dwell cycle.
   task automatic model_seg(input int n, input bit from_ena);
      logic [15:0] prev, frm;
      int cnt, st, f0;
      bit ev;
      prev = '0; cnt = 0; st = 0;
      for (int k = 0; k < n; k++) begin
         e_col[k]   = (from_ena && k == 0) ? 4'hF : ~(4'b0001 << ((k / SD) % 4));
         e_st[k]    = 0;
         e_valid[k] = 1'b0;
         e_code[k]  = model_code;
      end
      for (int f = 0; FR*f + FR - 1 < n; f++) begin
         frm = '0;
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               frm[r*4+c] = sched[FR*f + SD*c + SD - 3][r*4+c];
         if (frm == prev) cnt = (cnt < DS) ? cnt + 1 : cnt;
         else             cnt = 1;
         prev = frm;
         if (cnt >= DS) begin
            ev = 1'b0;
            if ($countones(frm) == 0)      st = 0;
            else if ($countones(frm) >= 2) st = 2;
            else if (st == 0) begin
               st = 1; ev = 1'b1; model_code = key_code_of(frm);
            end
            f0 = FR * (f + 1);
            for (int k = f0; k < n; k++) begin
               e_st[k] = st; e_code[k] = model_code;
            end
            if (f0 < n) e_valid[f0] = ev;
         end
      end
   endtask

   task automatic run_seg(input int n, input bit from_ena, output int pulses, output logic [3:0] last);
      model_seg(n, from_ena);
      pulses = 0;
      last = 4'h0;
      for (int k = 0; k < n; k++) begin
         keys = sched[k];
         #1;
         check_eq($sformatf("col_out@%0d", k), 16'(col_out), 16'(e_col[k]));
         check_eq($sformatf("key_valid@%0d", k), 16'(kif.key_valid), 16'(e_valid[k]));
         check_eq($sformatf("key_code@%0d", k), 16'(kif.key_code), 16'(e_code[k]));
         check_eq($sformatf("key_held@%0d", k), 16'(kif.key_held), 16'(e_st[k] == 1));
         check_eq($sformatf("multi_key@%0d", k), 16'(kif.multi_key), 16'(e_st[k] == 2));
         if (kif.key_valid === 1'b1) begin
            pulses++;
            last = kif.key_code;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_col_out"}, 16'(col_out), 16'(4'b1110));
      check_eq({tag, "_key_valid"}, 16'(kif.key_valid), 16'(0));
      check_eq({tag, "_key_code"}, 16'(kif.key_code), 16'(0));
      check_eq({tag, "_key_held"}, 16'(kif.key_held), 16'(0));
      check_eq({tag, "_multi_key"}, 16'(kif.multi_key), 16'(0));
   endtask

   task automatic restart(input logic [15:0] k_during);
      keys = k_during;
      ena = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("ena_col_out", 16'(col_out), 16'(4'hF));
      check_eq("ena_key_held", 16'(kif.key_held), 16'(0));
      check_eq("ena_multi_key", 16'(kif.multi_key), 16'(0));
      check_eq("ena_key_valid", 16'(kif.key_valid), 16'(0));
      check_eq("ena_key_code", 16'(kif.key_code), 16'(model_code));
      @(posedge clk);
      @(negedge clk);
      ena = 1'b1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < MAXC; i++) sched[i] = '0;
   endtask

   task automatic press(input int key, input int from, input int upto);
      for (int i = from; i < upto && i < MAXC; i++) sched[i][key] = 1'b1;
   endtask

   initial begin
      int pulses;
      logic [3:0] last;
      int pos, len, pick;
      logic [15:0] cur;

      model_code = 4'h0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      clear_sched();
      run_seg(48, 1'b0, pulses, last);
      check_eq("scan_pulses", 16'(pulses), 16'(0));

      // key 6 = row 1, col 2
      restart('0);
      clear_sched();
      press(6, 16, 64);
      run_seg(128, 1'b1, pulses, last);
      check_eq("press_pulses", 16'(pulses), 16'(1));
      check_eq("press_code", 16'(last), 16'(4'h6));
      check_eq("press_released", 16'(kif.key_held), 16'(0));

      // '*' = row 3, col 0, bouncing every 5 cycles for two frames
      restart('0);
      clear_sched();
      for (int i = 16; i < 48; i++) sched[i][12] = (((i - 16) / 5) % 2 == 0);
      press(12, 48, 128);
      run_seg(128, 1'b1, pulses, last);
      check_eq("bounce_pulses", 16'(pulses), 16'(1));
      check_eq("bounce_code", 16'(last), 16'(4'hE));

      // '1' and '9' together, release '9', release all, then '#'
      restart('0);
      clear_sched();
      press(0, 16, 112);
      press(10, 16, 64);
      press(14, 144, 224);
      run_seg(224, 1'b1, pulses, last);
      check_eq("multi_pulses", 16'(pulses), 16'(1));
      check_eq("multi_code", 16'(last), 16'(4'hF));

      // hold '5', press '8', release '5' within one frame
      restart('0);
      clear_sched();
      press(5, 16, 88);
      press(9, 80, 160);
      run_seg(160, 1'b1, pulses, last);
      check_eq("roll_pulses", 16'(pulses), 16'(1));
      check_eq("roll_code", 16'(kif.key_code), 16'(4'h5));

      // 'D' held across an enable drop
      restart('0);
      clear_sched();
      press(15, 8, 80);
      run_seg(80, 1'b1, pulses, last);
      check_eq("ena_first_pulses", 16'(pulses), 16'(1));
      check_eq("ena_first_code", 16'(last), 16'(4'hD));
      restart(16'h8000);
      clear_sched();
      press(15, 0, 64);
      run_seg(64, 1'b1, pulses, last);
      check_eq("ena_again_pulses", 16'(pulses), 16'(1));
      check_eq("ena_again_held", 16'(kif.key_held), 16'(1));

      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_code = 4'h0;
      clear_sched();
      run_seg(48, 1'b0, pulses, last);
      check_eq("post_reset_pulses", 16'(pulses), 16'(0));

      for (int s = 0; s < 4; s++) begin
         restart(16'($urandom));
         clear_sched();
         pos = 0;
         while (pos < 160) begin
            len  = $urandom_range(1, 24);
            pick = $urandom_range(0, 5);
            if (pick < 2)       cur = '0;
            else if (pick < 5)  cur = 16'h0001 << $urandom_range(0, 15);
            else                cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            for (int j = pos; j < pos + len && j < 160; j++) sched[j] = cur;
            pos += len;
         end
         run_seg(160, 1'b1, pulses, last);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
